// File: rtl/reg_cmd_bridge_if.sv
// Command-stream and register-strobe bundle for reg_cmd_bridge.
// master: drives rx_data/rx_valid, observes the strobes.
// slave:  the bridge; accepts bytes, drives the register strobes.
interface reg_cmd_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] reg_addr;
    logic [31:0] reg_wr_data;
    logic        reg_wr;
    logic        cmd_err;
    logic [15:0] wr_count;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  reg_addr,
        input  reg_wr_data,
        input  reg_wr,
        input  cmd_err,
        input  wr_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output reg_addr,
        output reg_wr_data,
        output reg_wr,
        output cmd_err,
        output wr_count
    );
endinterface

// File: rtl/reg_cmd_bridge.sv
// Byte-serial write-frame decoder feeding the control-register block.
// Frame: opcode, 4 address bytes, 4 data bytes (MSB first).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - slave side: rx_data/rx_valid/rx_ready byte stream in;
//          reg_addr/reg_wr_data/reg_wr strobes, cmd_err pulse and
//          saturating wr_count out.
module reg_cmd_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [7:0]  WR_OPCODE = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    reg_cmd_bridge_if.slave bus
);

    localparam logic [15:0] L_TMAX = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ISSUE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic [15:0] r_timer;
    logic [15:0] w_timer_nxt;
    logic [31:0] r_sh_addr;
    logic [31:0] w_sh_addr_nxt;
    logic [31:0] r_sh_data;
    logic [31:0] w_sh_data_nxt;

    logic [31:0] r_reg_addr;
    logic [31:0] r_reg_wr_data;
    logic        r_reg_wr;
    logic        r_cmd_err;
    logic [15:0] r_wr_count;

    logic        w_ready;
    logic        w_acc;
    logic        w_tmo;
    logic        w_issue;
    logic        w_err;

    // Ready is gated by rst so no byte is taken during the reset cycle.
    assign w_ready = ~rst & (r_state != ISSUE);
    assign w_acc   = bus.rx_valid & w_ready;
    // An accepted byte on the would-expire cycle wins over the abort.
    assign w_tmo   = (r_timer == L_TMAX) & ~w_acc;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timer_nxt   = r_timer;
        w_sh_addr_nxt = r_sh_addr;
        w_sh_data_nxt = r_sh_data;
        w_issue       = 1'b0;
        w_err         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_acc) begin
                    if (bus.rx_data == WR_OPCODE) begin
                        w_state_nxt   = ADDR;
                        w_cnt_nxt     = 2'd0;
                        w_timer_nxt   = 16'd0;
                        w_sh_addr_nxt = 32'd0;
                        w_sh_data_nxt = 32'd0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (w_acc) begin
                    w_sh_addr_nxt = {r_sh_addr[23:0], bus.rx_data};
                    w_timer_nxt   = 16'd0;
                    w_cnt_nxt     = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = 2'd0;
                    end
                end else if (w_tmo) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = 2'd0;
                    w_timer_nxt   = 16'd0;
                    w_sh_addr_nxt = 32'd0;
                    w_sh_data_nxt = 32'd0;
                    w_err         = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            DATA: begin
                if (w_acc) begin
                    w_sh_data_nxt = {r_sh_data[23:0], bus.rx_data};
                    w_timer_nxt   = 16'd0;
                    w_cnt_nxt     = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = ISSUE;
                        w_cnt_nxt   = 2'd0;
                        w_issue     = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = 2'd0;
                    w_timer_nxt   = 16'd0;
                    w_sh_addr_nxt = 32'd0;
                    w_sh_data_nxt = 32'd0;
                    w_err         = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            ISSUE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 2'd0;
            r_timer   <= 16'd0;
            r_sh_addr <= 32'd0;
            r_sh_data <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timer   <= w_timer_nxt;
            r_sh_addr <= w_sh_addr_nxt;
            r_sh_data <= w_sh_data_nxt;
        end
    end

    // Strobes are loaded on the edge that takes the 9th byte so that
    // reg_wr is high during the ISSUE cycle with the new addr/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_addr    <= 32'd0;
            r_reg_wr_data <= 32'd0;
            r_reg_wr      <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_wr_count    <= 16'd0;
        end else begin
            r_reg_wr  <= w_issue;
            r_cmd_err <= w_err;
            if (w_issue) begin
                r_reg_addr    <= w_sh_addr_nxt;
                r_reg_wr_data <= w_sh_data_nxt;
                if (r_wr_count != 16'hFFFF) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
            end
        end
    end

    assign bus.rx_ready    = w_ready;
    assign bus.reg_addr    = r_reg_addr;
    assign bus.reg_wr_data = r_reg_wr_data;
    assign bus.reg_wr      = r_reg_wr;
    assign bus.cmd_err     = r_cmd_err;
    assign bus.wr_count    = r_wr_count;

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// Testbench for reg_cmd_bridge: directed frames, error cases,
// reset mid-frame and randomised gap traffic against a scoreboard.
module tb_reg_cmd_bridge;

    localparam int unsigned TMO = 8;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    int   cyc;
    int   n_wr;
    int   n_err;
    int   exp_cnt;
    logic [7:0] op_type;
    wr_t  exp_q[$];

    reg_cmd_bridge_if bus();

    reg_cmd_bridge #(
        .TIMEOUT  (TMO),
        .WR_OPCODE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the downstream register block: address 10 is op_type.
    always @(posedge clk) begin
        if (rst) op_type <= 8'd0;
        else if (bus.reg_wr && bus.reg_addr == 32'hA)
            op_type <= bus.reg_wr_data[7:0];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Continuous monitor: scoreboard pop on every strobe, hold check
    // otherwise, and the strobe/error exclusivity rule.
    logic        prev_rst;
    logic [31:0] prev_a;
    logic [31:0] prev_d;
    always @(negedge clk) begin : mon
        wr_t e;
        if (!rst && !prev_rst) begin
            if (bus.reg_wr) begin
                n_wr++;
                chk("wr_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(bus.reg_addr), 64'(e.a));
                    chk("wr_data", 64'(bus.reg_wr_data), 64'(e.d));
                end
            end else begin
                chk("hold_addr", 64'(bus.reg_addr), 64'(prev_a));
                chk("hold_data", 64'(bus.reg_wr_data), 64'(prev_d));
            end
            chk("wr_err_excl", 64'(bus.reg_wr & bus.cmd_err), 64'd0);
            if (bus.cmd_err) n_err++;
        end
        prev_rst = rst;
        prev_a   = bus.reg_addr;
        prev_d   = bus.reg_wr_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    // Present one byte and wait (bounded) for the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        do begin
            acc = bus.rx_ready;
            tick();
            n++;
        end while (!acc && n < 20);
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] d,
                              input int maxgap);
        logic [71:0] f;
        int g;
        wr_t e;
        f = {8'hA5, a, d};
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        if (exp_cnt < 65535) exp_cnt++;
        for (int i = 0; i < 9; i++) begin
            send_byte(f[71 - 8*i -: 8]);
            if (i < 8 && maxgap > 0) begin
                g = $urandom_range(0, maxgap);
                if (g > 0) begin
                    drop();
                    repeat (g) tick();
                end
            end
        end
    endtask

    initial begin : main
        int e0;
        int w0;
        int c1;
        wr_t e;
        n_vec = 0; n_bad = 0; cyc = 0; n_wr = 0; n_err = 0;
        exp_cnt = 0;
        prev_rst = 1'b1;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        tick();
        tick();
        chk("rst_ready", 64'(bus.rx_ready), 64'd0);
        chk("rst_addr", 64'(bus.reg_addr), 64'd0);
        chk("rst_data", 64'(bus.reg_wr_data), 64'd0);
        chk("rst_wr", 64'(bus.reg_wr), 64'd0);
        chk("rst_err", 64'(bus.cmd_err), 64'd0);
        chk("rst_cnt", 64'(bus.wr_count), 64'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 64'(bus.rx_ready), 64'd1);

        // Basic frame to op_type register
        send_frame(32'h0000000A, 32'h00000002, 0);
        drop();
        chk("t1_wr", 64'(bus.reg_wr), 64'd1);
        chk("t1_ready", 64'(bus.rx_ready), 64'd0);
        chk("t1_addr", 64'(bus.reg_addr), 64'hA);
        chk("t1_data", 64'(bus.reg_wr_data), 64'h2);
        chk("t1_cnt", 64'(bus.wr_count), 64'(exp_cnt));
        tick();
        chk("t1_wr_off", 64'(bus.reg_wr), 64'd0);
        chk("t1_ready_back", 64'(bus.rx_ready), 64'd1);
        chk("t1_op_type", 64'(op_type), 64'd2);

        // Bad opcodes back to back, then a good frame
        e0 = n_err;
        send_byte(8'h3C);
        chk("t2_err1", 64'(bus.cmd_err), 64'd1);
        send_byte(8'h3D);
        chk("t2_err2", 64'(bus.cmd_err), 64'd1);
        chk("t2_no_wr", 64'(bus.reg_wr), 64'd0);
        drop();
        tick();
        chk("t2_err_off", 64'(bus.cmd_err), 64'd0);
        send_frame(32'h00000014, 32'hDEADBEEF, 0);
        drop();
        chk("t2_addr", 64'(bus.reg_addr), 64'h14);
        chk("t2_data", 64'(bus.reg_wr_data), 64'hDEADBEEF);
        chk("t2_cnt", 64'(bus.wr_count), 64'(exp_cnt));
        tick();
        chk("t2_err_count", 64'(n_err - e0), 64'd2);

        // Timeout in ADDR
        e0 = n_err;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        drop();
        repeat (TMO - 1) tick();
        chk("t3_no_abort_yet", 64'(bus.cmd_err), 64'd0);
        tick();
        chk("t3_abort", 64'(bus.cmd_err), 64'd1);
        tick();
        chk("t3_abort_off", 64'(bus.cmd_err), 64'd0);
        send_frame(32'h11223344, 32'h55667788, 0);
        drop();
        chk("t3_addr", 64'(bus.reg_addr), 64'h11223344);
        chk("t3_data", 64'(bus.reg_wr_data), 64'h55667788);
        tick();
        chk("t3_err_count", 64'(n_err - e0), 64'd1);

        // Byte lands on the would-expire cycle: no abort
        e0 = n_err;
        e.a = 32'h00001234;
        e.d = 32'hCAFEF00D;
        exp_q.push_back(e);
        exp_cnt++;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        drop();
        repeat (TMO - 1) tick();
        send_byte(8'h12);
        chk("t3b_no_err", 64'(bus.cmd_err), 64'd0);
        send_byte(8'h34);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hF0);
        send_byte(8'h0D);
        drop();
        chk("t3b_wr", 64'(bus.reg_wr), 64'd1);
        chk("t3b_addr", 64'(bus.reg_addr), 64'h1234);
        tick();
        chk("t3b_err_count", 64'(n_err - e0), 64'd0);

        // Timeout in DATA, shadows must not leak into the next frame
        e0 = n_err;
        send_byte(8'hA5);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        drop();
        repeat (TMO) tick();
        chk("t3c_abort", 64'(bus.cmd_err), 64'd1);
        send_frame(32'h0BADF00D, 32'h600DCAFE, 0);
        drop();
        chk("t3c_data", 64'(bus.reg_wr_data), 64'h600DCAFE);
        tick();
        chk("t3c_err_count", 64'(n_err - e0), 64'd1);

        // Back-to-back frames with rx_valid held high
        w0 = n_wr;
        send_frame(32'hA0A0A0A0, 32'h01010101, 0);
        c1 = cyc;
        send_frame(32'hB0B0B0B0, 32'h02020202, 0);
        chk("t4_period", 64'(cyc - c1), 64'd10);
        drop();
        chk("t4_cnt", 64'(bus.wr_count), 64'(exp_cnt));
        tick();
        chk("t4_pulses", 64'(n_wr - w0), 64'd2);

        // Reset after byte 6
        send_byte(8'hA5);
        for (int i = 1; i <= 5; i++) send_byte(8'(8'h70 + i));
        drop();
        rst = 1'b1;
        exp_cnt = 0;
        tick();
        chk("t5_ready", 64'(bus.rx_ready), 64'd0);
        chk("t5_addr", 64'(bus.reg_addr), 64'd0);
        chk("t5_data", 64'(bus.reg_wr_data), 64'd0);
        chk("t5_wr", 64'(bus.reg_wr), 64'd0);
        chk("t5_err", 64'(bus.cmd_err), 64'd0);
        chk("t5_cnt", 64'(bus.wr_count), 64'd0);
        rst = 1'b0;
        tick();
        chk("t5_ready_back", 64'(bus.rx_ready), 64'd1);
        send_frame(32'h00000020, 32'h12345678, 0);
        drop();
        chk("t5_addr2", 64'(bus.reg_addr), 64'h20);
        chk("t5_cnt2", 64'(bus.wr_count), 64'(exp_cnt));
        tick();

        // Randomised gaps below TIMEOUT over 100 frames
        rst = 1'b1;
        exp_cnt = 0;
        tick();
        rst = 1'b0;
        tick();
        e0 = n_err;
        w0 = n_wr;
        for (int k = 0; k < 100; k++) begin
            drop();
            repeat ($urandom_range(0, 5)) tick();
            send_frame($urandom, $urandom, TMO - 1);
        end
        drop();
        repeat (3) tick();
        chk("t6_cnt", 64'(bus.wr_count), 64'(exp_cnt));
        chk("t6_cnt_100", 64'(exp_cnt), 64'd100);
        chk("t6_pulses", 64'(n_wr - w0), 64'd100);
        chk("t6_no_err", 64'(n_err - e0), 64'd0);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
